ser_tx_negsample: RTL and testbench

Serial transmitter that launches a parallel word MSB-first as a serial bit stream, together with a generated serial clock SCLK and an active-low frame select SCS. SDO changes only at rising SCLK edges, so a downstream negative-edge D-FF receiver samples each bit mid-bit on falling SCLK. This block is the launching end of the negedge-sampling serial link; the existing negative-edge flip-flop block is the capturing end.

---
 rtl/ser_tx_negsample_if.sv | 33 +++
 rtl/ser_tx_negsample.sv | 170 +++++++++++++++++
 tb/tb_ser_tx_negsample.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ser_tx_negsample_if.sv
// Frame request and serial-link signals for ser_tx_negsample.
// master is the requesting side, slave is the transmitter.
interface ser_tx_negsample_if #(
    parameter int DATA_W = 8
);
    logic              START;
    logic [DATA_W-1:0] DIN;
    logic              BUSY;
    logic              DONE;
    logic              SCLK;
    logic              SDO;
    logic              SCS;

    modport master (
        output START,
        output DIN,
        input  BUSY,
        input  DONE,
        input  SCLK,
        input  SDO,
        input  SCS
    );

    modport slave (
        input  START,
        input  DIN,
        output BUSY,
        output DONE,
        output SCLK,
        output SDO,
        output SCS
    );
endinterface

// File: rtl/ser_tx_negsample.sv
// MSB-first serial transmitter; SDO launches on rising SCLK so a
// negedge receiver samples mid-bit. All outputs are registered.
module ser_tx_negsample #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              CLK,
    input  logic              RST,
    ser_tx_negsample_if.slave bus
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [BW-1:0]     bit_q;
    logic [BW-1:0]     bit_d;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;
    logic              sclk_q;
    logic              sclk_d;
    logic              sdo_q;
    logic              sdo_d;
    logic              scs_q;
    logic              scs_d;

    logic              tick;
    logic              last_bit;

    assign tick     = (cnt_q == CNT_LAST);
    assign last_bit = (bit_q == BIT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick && sclk_q && last_bit) begin
                    state_d = TRAIL;
                end
            end
            TRAIL: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shift happens on falls (internal only); SDO loads the new MSB on rises.
    always_comb begin
        cnt_d   = '0;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sclk_d  = sclk_q;
        sdo_d   = sdo_q;
        scs_d   = scs_q;
        if ((state_q != IDLE) && !tick) begin
            cnt_d = cnt_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    shreg_d = bus.DIN;
                    sdo_d   = bus.DIN[DATA_W-1];
                    scs_d   = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                end
            end
            LEAD: begin
                if (tick) begin
                    sclk_d = 1'b1;
                    sdo_d  = shreg_q[DATA_W-1];
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d  = 1'b0;
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q << 1;
                    end else begin
                        sclk_d = 1'b1;
                        sdo_d  = shreg_q[DATA_W-1];
                    end
                end
            end
            TRAIL: begin
                if (tick) begin
                    scs_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sdo_d   = 1'b0;
                    bit_d   = '0;
                    shreg_d = '0;
                end
            end
            default: begin
                sclk_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            scs_q   <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            scs_q   <= scs_d;
        end
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.SCLK = sclk_q;
    assign bus.SDO  = sdo_q;
    assign bus.SCS  = scs_q;
endmodule

// File: tb/tb_ser_tx_negsample.sv
// Bench for ser_tx_negsample: negedge receiver model plus scoreboard,
// one 8-bit/div-2 instance and one 4-bit/div-1 instance.
module tb_ser_tx_negsample;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ser_tx_negsample_if #(.DATA_W(8)) ba ();
    ser_tx_negsample_if #(.DATA_W(4)) bb ();

    ser_tx_negsample #(.DATA_W(8), .CLK_DIV(2)) dut_a (
        .CLK (clk),
        .RST (rst),
        .bus (ba.slave)
    );

    ser_tx_negsample #(.DATA_W(4), .CLK_DIV(1)) dut_b (
        .CLK (clk),
        .RST (rst),
        .bus (bb.slave)
    );

    // Negative-edge D-FF shift-register receivers
    logic [7:0] rx_a = 8'h00;
    logic [3:0] rx_b = 4'h0;
    int         fall_a = 0;
    int         fall_b = 0;

    always @(negedge ba.SCLK) begin
        rx_a = {rx_a[6:0], ba.SDO};
        fall_a++;
    end

    always @(negedge bb.SCLK) begin
        rx_b = {rx_b[2:0], bb.SDO};
        fall_b++;
    end

    // SDO may only move with a rising SCLK inside a frame; SCLK is still while SCS=1
    int   viol = 0;
    logic p_sclk = 1'b0;
    logic p_sdo = 1'b0;
    logic p_scs = 1'b1;

    always @(posedge clk) begin
        #1;
        if (p_scs === 1'b0 && ba.SCS === 1'b0 && ba.SDO !== p_sdo
            && !(p_sclk === 1'b0 && ba.SCLK === 1'b1)) viol++;
        if (p_scs === 1'b1 && ba.SCS === 1'b1 && ba.SCLK !== p_sclk) viol++;
        p_sclk = ba.SCLK;
        p_sdo  = ba.SDO;
        p_scs  = ba.SCS;
    end

    int         vec = 0;
    int         bad = 0;
    logic [7:0] sb_a[$];
    logic [3:0] sb_b[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] w);
        ba.START = 1'b1;
        ba.DIN   = w;
        step();
        ba.START = 1'b0;
        sb_a.push_back(w);
    endtask

    task automatic pop_a(input string tag);
        logic [7:0] e;
        e = (sb_a.size() > 0) ? sb_a.pop_front() : 8'hxx;
        chk(tag, {24'h0, rx_a}, {24'h0, e});
    endtask

    // Starts in cycle 1; returns in the DONE cycle or after the bound
    task automatic run_a(input int inj_at, input logic [7:0] inj_w,
                         output int done_at, output int last_fall);
        logic ps;
        ps        = ba.SCLK;
        done_at   = -1;
        last_fall = -1;
        for (int n = 1; n <= 80; n++) begin
            if (ps === 1'b1 && ba.SCLK === 1'b0) last_fall = n;
            ps = ba.SCLK;
            if (ba.DONE === 1'b1) begin
                done_at = n;
                return;
            end
            if (n == inj_at) begin
                ba.START = 1'b1;
                ba.DIN   = inj_w;
            end
            step();
            ba.START = 1'b0;
        end
    endtask

    task automatic quiet_a(input string tag, input int cycles);
        int hits;
        hits = 0;
        for (int n = 0; n < cycles; n++) begin
            step();
            if (ba.DONE !== 1'b0 || ba.BUSY !== 1'b0) hits++;
        end
        chk(tag, hits, 0);
    endtask

    initial begin
        int d;
        int d2;
        int lf;
        int f0;
        rst      = 1'b1;
        ba.START = 1'b0;
        ba.DIN   = 8'h00;
        bb.START = 1'b0;
        bb.DIN   = 4'h0;
        repeat (3) step();
        chk("rst_busy", ba.BUSY, 1'b0);
        chk("rst_done", ba.DONE, 1'b0);
        chk("rst_sclk", ba.SCLK, 1'b0);
        chk("rst_sdo", ba.SDO, 1'b0);
        chk("rst_scs", ba.SCS, 1'b1);
        rst = 1'b0;
        step();

        // Basic frame
        f0 = fall_a;
        send_a(8'hA5);
        chk("a5_lead_scs", ba.SCS, 1'b0);
        chk("a5_lead_busy", ba.BUSY, 1'b1);
        run_a(0, 8'h00, d, lf);
        chk("a5_done_cycle", d, 35);
        chk("a5_last_fall", lf, 33);
        chk("a5_falls", fall_a - f0, 8);
        chk("a5_done_busy", ba.BUSY, 1'b0);
        chk("a5_done_scs", ba.SCS, 1'b1);
        pop_a("a5_rx");
        step();
        chk("a5_done_width", ba.DONE, 1'b0);

        // Launch/sample alignment, DIN changed after acceptance
        send_a(8'h3C);
        chk("3c_msb_c1", ba.SDO, 1'b0);
        ba.DIN = 8'hC3;
        run_a(0, 8'h00, d, lf);
        chk("3c_done_cycle", d, 35);
        pop_a("3c_rx");

        // START while busy is ignored
        step();
        send_a(8'h00);
        run_a(10, 8'hFF, d, lf);
        chk("ign_done_cycle", d, 35);
        pop_a("ign_rx");
        quiet_a("ign_no_second", 40);

        // Back-to-back frames
        send_a(8'h81);
        run_a(0, 8'h00, d, lf);
        chk("b2b_first_done", d, 35);
        pop_a("b2b_rx81");
        chk("b2b_gap_scs", ba.SCS, 1'b1);
        ba.START = 1'b1;
        ba.DIN   = 8'h7E;
        step();
        ba.START = 1'b0;
        sb_a.push_back(8'h7E);
        chk("b2b_scs_low", ba.SCS, 1'b0);
        run_a(0, 8'h00, d2, lf);
        chk("b2b_done_gap", d2, 35);
        pop_a("b2b_rx7e");

        // Reset mid-frame
        step();
        send_a(8'hC3);
        for (int n = 1; n < 12; n++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(sb_a.pop_front());
        chk("abort_sclk", ba.SCLK, 1'b0);
        chk("abort_scs", ba.SCS, 1'b1);
        chk("abort_busy", ba.BUSY, 1'b0);
        chk("abort_sdo", ba.SDO, 1'b0);
        chk("abort_done", ba.DONE, 1'b0);
        quiet_a("abort_no_done", 40);

        // RST wins over START in the same cycle
        rst      = 1'b1;
        ba.START = 1'b1;
        ba.DIN   = 8'hFF;
        step();
        rst      = 1'b0;
        ba.START = 1'b0;
        chk("rststart_busy", ba.BUSY, 1'b0);
        chk("rststart_scs", ba.SCS, 1'b1);
        quiet_a("rststart_idle", 5);

        send_a(8'h5A);
        run_a(0, 8'h00, d, lf);
        chk("post_rst_done", d, 35);
        pop_a("post_rst_rx");

        // Minimum divider on the 4-bit instance
        step();
        f0       = fall_b;
        bb.START = 1'b1;
        bb.DIN   = 4'b1001;
        step();
        bb.START = 1'b0;
        sb_b.push_back(4'b1001);
        for (int n = 1; n <= 9; n++) begin
            chk($sformatf("div1_sclk_c%0d", n), bb.SCLK, 1'((n % 2) == 0));
            step();
        end
        chk("div1_done_c10", bb.DONE, 1'b1);
        chk("div1_falls", fall_b - f0, 4);
        begin
            logic [3:0] e;
            e = (sb_b.size() > 0) ? sb_b.pop_front() : 4'hx;
            chk("div1_rx", {28'h0, rx_b}, {28'h0, e});
        end
        step();
        chk("div1_done_width", bb.DONE, 1'b0);

        chk("align_violations", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
